// File: rtl/div_seq_pkg.sv
// Shared definitions for the EXE-stage divider sequencer: state encoding and
// the length of the divider clear pulse issued after a flush.
package div_seq_pkg;

  typedef enum logic [2:0] {
    DS_IDLE   = 3'd0,
    DS_LAUNCH = 3'd1,
    DS_RUN    = 3'd2,
    DS_DONE   = 3'd3,
    DS_FLUSH  = 3'd4
  } div_seq_state_t;

  localparam int DIV_FLUSH_CYCLES = 2;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Handshake bundle between the divider sequencer (master) and the iterative
// divider (slave): start/clear control, latched operands, result and busy.
interface div_seq_ctrl_if
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic               div_start;
  logic               div_clr;
  logic               div_sign;
  logic [WIDTH-1:0]   div_a;
  logic [WIDTH-1:0]   div_b;
  logic [2*WIDTH-1:0] div_result;
  logic               div_busy;

  modport master (
    output div_start, div_clr, div_sign, div_a, div_b,
    input  div_result, div_busy
  );

  modport slave (
    input  div_start, div_clr, div_sign, div_a, div_b,
    output div_result, div_busy
  );

endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer between EXE and the iterative divider: launches div/divu, stalls
// until the result is back, writes HI/LO once, and clears the divider on flush.
// Optional macro DIV_SEQ_ZERO_BYPASS_EN retires divide-by-zero without a launch.
module div_seq_ctrl
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_div_req,
  input  logic             ex_div_sign,
  input  logic [WIDTH-1:0] ex_op_a,
  input  logic [WIDTH-1:0] ex_op_b,
  input  logic             ex_flush,
  input  logic             ex_hold,
  output logic             ex_stall,
  div_seq_ctrl_if.master   dif,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata
);

  localparam logic [2:0] ST_IDLE    = DS_IDLE;
  localparam logic [2:0] ST_LAUNCH  = DS_LAUNCH;
  localparam logic [2:0] ST_RUN     = DS_RUN;
  localparam logic [2:0] ST_DONE    = DS_DONE;
  localparam logic [2:0] ST_FLUSH   = DS_FLUSH;
  localparam logic [1:0] FLUSH_LAST = 2'(DIV_FLUSH_CYCLES - 1);

  logic [2:0]       state_reg, state_next;
  logic [1:0]       flush_cnt_reg;
  logic             start_reg, clr_reg, sign_reg, we_pend_reg;
  logic [WIDTH-1:0] a_reg, b_reg, hi_reg, lo_reg;
  logic             zero_div, launch;

`ifdef DIV_SEQ_ZERO_BYPASS_EN
  assign zero_div = (ex_op_b == '0);
`else
  assign zero_div = 1'b0;
`endif

  assign launch = ex_div_req & ~ex_flush & ~zero_div;

  always_comb begin
    state_next = state_reg;
    ex_stall   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ex_stall = launch;
        if (launch) state_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        ex_stall   = 1'b1;
        state_next = ex_flush ? ST_FLUSH : ST_RUN;
      end
      ST_RUN: begin
        ex_stall = 1'b1;
        if (ex_flush)           state_next = ST_FLUSH;
        else if (!dif.div_busy) state_next = ST_DONE;
      end
      ST_DONE: begin
        // Holding in DONE keeps the same instruction from being relaunched.
        if (ex_flush)      state_next = ST_FLUSH;
        else if (!ex_hold) state_next = ST_IDLE;
      end
      ST_FLUSH: begin
        ex_stall = ex_div_req;
        if (flush_cnt_reg == FLUSH_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      flush_cnt_reg <= '0;
      start_reg     <= 1'b0;
      clr_reg       <= 1'b0;
      sign_reg      <= 1'b0;
      we_pend_reg   <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
    end else begin
      state_reg   <= state_next;
      we_pend_reg <= 1'b0;
      if (state_reg == ST_IDLE && launch) begin
        a_reg     <= ex_op_a;
        b_reg     <= ex_op_b;
        sign_reg  <= ex_div_sign;
        start_reg <= 1'b1;
      end
      if (state_reg == ST_RUN && state_next == ST_DONE) begin
        hi_reg      <= dif.div_result[2*WIDTH-1:WIDTH];
        lo_reg      <= dif.div_result[WIDTH-1:0];
        start_reg   <= 1'b0;
        we_pend_reg <= 1'b1;
      end
      // Clear pulse spans the whole FLUSH stay so the divider is idle on exit.
      if (state_next == ST_FLUSH && state_reg != ST_FLUSH) begin
        start_reg     <= 1'b0;
        clr_reg       <= 1'b1;
        flush_cnt_reg <= '0;
      end else if (state_reg == ST_FLUSH) begin
        flush_cnt_reg <= flush_cnt_reg + 2'd1;
        if (state_next == ST_IDLE) clr_reg <= 1'b0;
      end
    end
  end

  assign dif.div_start = start_reg;
  assign dif.div_clr   = clr_reg;
  assign dif.div_sign  = sign_reg;
  assign dif.div_a     = a_reg;
  assign dif.div_b     = b_reg;
  assign hi_wdata      = hi_reg;
  assign lo_wdata      = lo_reg;
  // A flush arriving in the first DONE cycle suppresses the pending write.
  assign hilo_we       = we_pend_reg & ~ex_flush;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized bench for div_seq_ctrl with a behavioural divider and an
// arithmetic reference for quotient, remainder and stall/write timing.
module tb_div_seq_ctrl;

`ifdef DIV_SEQ_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk, rst_n;
  logic        ex_div_req, ex_div_sign, ex_flush, ex_hold;
  logic [31:0] ex_op_a, ex_op_b;
  logic        ex_stall, hilo_we;
  logic [31:0] hi_wdata, lo_wdata;

  int n_checks = 0;
  int n_pass   = 0;
  int dv_lat   = 33;

  div_seq_ctrl_if #(.WIDTH(32)) dif ();

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_div_req(ex_div_req), .ex_div_sign(ex_div_sign),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_flush(ex_flush), .ex_hold(ex_hold),
    .ex_stall(ex_stall), .dif(dif),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
    return {r, q};
  endfunction

  // Divider: busy for dv_lat cycles after sampling start, then waits for start low.
  logic [1:0] dv_st;
  int         dv_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_st <= 2'd0; dv_cnt <= 0;
      dif.div_busy <= 1'b0; dif.div_result <= 64'd0;
    end else if (dif.div_clr) begin
      dv_st <= 2'd0; dif.div_busy <= 1'b0;
    end else begin
      case (dv_st)
        2'd0: if (dif.div_start) begin
          dv_st <= 2'd1; dv_cnt <= dv_lat; dif.div_busy <= 1'b1;
          dif.div_result <= {$urandom, $urandom};
        end
        2'd1: if (dv_cnt <= 1) begin
          dv_st <= 2'd2; dif.div_busy <= 1'b0;
          dif.div_result <= ref_div(dif.div_sign, dif.div_a, dif.div_b);
        end else begin
          dv_cnt <= dv_cnt - 1;
        end
        default: if (!dif.div_start) dv_st <= 2'd0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One instruction from first sight in EXE until it leaves (after hold_n held cycles).
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold_n,
                        output logic [31:0] lo_got, output logic [31:0] hi_got);
    logic [63:0] exp;
    bit   bypass;
    int   done_c, last_c, instr_last, stall_cnt, we_cnt, we_at, clr_cnt, start_late;
    logic start1;
    exp        = ref_div(sgn, a, b);
    bypass     = BYPASS && (b == 32'd0);
    done_c     = bypass ? 0 : lat + 3;
    last_c     = bypass ? 1 : done_c + hold_n;
    instr_last = bypass ? 0 : last_c;
    stall_cnt = 0; we_cnt = 0; we_at = -1; clr_cnt = 0; start_late = 0;
    start1 = 1'b0; lo_got = 32'd0; hi_got = 32'd0;
    dv_lat = lat;
    for (int c = 0; c <= last_c; c++) begin
      ex_div_req = (c <= instr_last); ex_div_sign = sgn;
      ex_op_a = a; ex_op_b = b; ex_flush = 1'b0;
      ex_hold = !bypass && (c >= done_c) && (c < last_c);
      #4;
      if (ex_stall) stall_cnt++;
      if (dif.div_clr) clr_cnt++;
      if (c == 1) start1 = dif.div_start;
      if (c >= done_c && dif.div_start) start_late++;
      if (hilo_we) begin
        we_cnt++;
        if (we_at < 0) begin we_at = c; lo_got = lo_wdata; hi_got = hi_wdata; end
      end
      @(posedge clk); #1;
    end
    ex_div_req = 1'b0; ex_hold = 1'b0;
    check("stall_len", stall_cnt, done_c);
    check("we_count", we_cnt, bypass ? 0 : 1);
    check("clr_idle", clr_cnt, 0);
    check("start_after_done", start_late, 0);
    if (!bypass) begin
      check("start_c1", start1, 1'b1);
      check("we_cycle", we_at, done_c);
      check("lo", lo_got, exp[31:0]);
      check("hi", hi_got, exp[63:32]);
    end
    $display("div sgn=%0d a=%h b=%h lat=%0d hold=%0d -> we@%0d lo=%h hi=%h",
             sgn, a, b, lat, hold_n, we_at, lo_got, hi_got);
  endtask

  // Instruction killed by a flush in cycle flush_c (0 = still in IDLE).
  task automatic do_flush(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int flush_c);
    bit   launched;
    int   clr_cnt, we_cnt;
    logic clr1, start1, stall0;
    launched = (flush_c >= 1) && !(BYPASS && b == 32'd0);
    clr_cnt = 0; we_cnt = 0; clr1 = 1'b0; start1 = 1'b1; stall0 = 1'b1;
    dv_lat = lat;
    for (int c = 0; c <= flush_c + 2; c++) begin
      ex_div_req = (c <= flush_c); ex_flush = (c == flush_c); ex_hold = 1'b0;
      ex_div_sign = sgn; ex_op_a = a; ex_op_b = b;
      #4;
      if (c == 0) stall0 = ex_stall;
      if (hilo_we) we_cnt++;
      if (c > flush_c && dif.div_clr) clr_cnt++;
      if (c == flush_c + 1) begin clr1 = dif.div_clr; start1 = dif.div_start; end
      @(posedge clk); #1;
    end
    ex_div_req = 1'b0; ex_flush = 1'b0;
    check("flush_we", we_cnt, 0);
    check("flush_clr_len", clr_cnt, launched ? 2 : 0);
    check("flush_clr1", clr1, launched);
    check("flush_start", start1, 1'b0);
    if (flush_c == 0) check("idle_flush_stall", stall0, 1'b0);
    $display("flush sgn=%0d a=%h b=%h lat=%0d at=%0d clr_cycles=%0d",
             sgn, a, b, lat, flush_c, clr_cnt);
  endtask

  initial begin
    logic [31:0] lo, hi, a, b;
    logic        sgn;
    int          lat;
    rst_n = 1'b0; ex_div_req = 1'b0; ex_div_sign = 1'b0; ex_flush = 1'b0;
    ex_hold = 1'b0; ex_op_a = 32'd0; ex_op_b = 32'd0;
    @(posedge clk); #4;
    check("rst_stall", ex_stall, 1'b0);
    check("rst_start", dif.div_start, 1'b0);
    check("rst_clr", dif.div_clr, 1'b0);
    check("rst_sign", dif.div_sign, 1'b0);
    check("rst_ops", {dif.div_a, dif.div_b}, 64'd0);
    check("rst_we", hilo_we, 1'b0);
    check("rst_hilo", {hi_wdata, lo_wdata}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_div(1'b0, 32'd100, 32'd7, 33, 0, lo, hi);
    check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, 0, lo, hi);
    check("div_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    do_flush(1'b0, 32'd1234, 32'd5, 33, 10);
    do_div(1'b0, 32'd9, 32'd3, 33, 0, lo, hi);
    check("after_flush_9_3", {hi, lo}, {32'd0, 32'd3});

    do_div(1'b0, 32'd50, 32'd4, 33, 3, lo, hi);

    do_div(1'b0, 32'd10, 32'd3, 33, 0, lo, hi);
    check("b2b_first", {hi, lo}, {32'd1, 32'd3});
    do_div(1'b0, 32'd20, 32'd6, 33, 0, lo, hi);
    check("b2b_second", {hi, lo}, {32'd2, 32'd3});

    do_div(1'b0, 32'd5, 32'd0, 33, 0, lo, hi);

    do_flush(1'b0, 32'd77, 32'd3, 33, 0);
    do_flush(1'b1, 32'd77, 32'd3, 33, 1);
    do_flush(1'b0, 32'd77, 32'd3, 5, 8);
    do_flush(1'b0, 32'd77, 32'd3, 5, 7);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4, 1, lo, hi);

    for (int i = 0; i < 16; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      lat = $urandom_range(1, 40);
      if ($urandom_range(0, 4) == 0)
        do_flush(sgn, a, b, lat, $urandom_range(0, lat + 3));
      else
        do_div(sgn, a, b, lat, $urandom_range(0, 2), lo, hi);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
# div_seq_ctrl

Sequencer between the EXE stage and the iterative 32-bit divider. It accepts `div`/`divu` requests from the pipeline and latches the operands. It drives the divider's `start`/`clr` handshake and stalls the pipeline until the quotient and remainder are ready, then issues a single HI/LO write. It also cancels in-flight divisions on pipeline flush and returns the divider to its idle state before a new request can be launched.

## Interface
Parameters:
- `WIDTH`, 32: operand width.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ex_div_req` in 1: EXE holds a div instruction; level, held until the instruction leaves EXE.
- `ex_div_sign` in 1: 1 = `div`, 0 = `divu`.
- `ex_op_a` in WIDTH: dividend.
- `ex_op_b` in WIDTH: divisor.
- `ex_flush` in 1: exception/flush; kills any division.
- `ex_hold` in 1: downstream freeze; EXE instruction does not advance this cycle.
- `ex_stall` out 1: stall request to the pipeline (combinational).
- `div_start` out 1: divider start (registered).
- `div_clr` out 1: divider clear (registered).
- `div_sign` out 1: divider signed mode (registered).
- `div_a` out WIDTH: latched dividend.
- `div_b` out WIDTH: latched divisor.
- `div_result` in 2*WIDTH: {remainder, quotient}; valid when `div_busy` = 0 after a run.
- `div_busy` in 1: divider busy.
- `hilo_we` out 1: one-cycle HI/LO write strobe.
- `hi_wdata` out WIDTH: remainder.
- `lo_wdata` out WIDTH: quotient.

## Operation
States: IDLE, LAUNCH, RUN, DONE, FLUSH.
- **IDLE**
  - Request with no flush: latch operands and sign, set `div_start` <= 1, go to LAUNCH.
  - `ex_stall` = `ex_div_req` & !`ex_flush`.
- **LAUNCH**
  - One cycle in which the divider samples start.
  - Go to RUN.
- **RUN**
  - `div_start` stays 1; operands are held stable.
  - When `div_busy` = 0: register `div_result[2W-1:W]` into `hi_wdata` and `div_result[W-1:0]` into `lo_wdata`, set `div_start` <= 0, go to DONE.
- **DONE**
  - `ex_stall` = 0.
  - `hilo_we` = 1 on the first DONE cycle only.
  - Stay in DONE while `ex_hold` = 1, so the same instruction is not relaunched. Otherwise go to IDLE.
- **FLUSH**
  - `div_clr` = 1 and `div_start` = 0 for exactly 2 cycles (covers divider divide-by-zero path), then go to IDLE.
  - `ex_stall` = `ex_div_req` during FLUSH.
- **Flush priority**
  - `ex_flush` in LAUNCH, RUN or DONE goes to FLUSH next cycle. No `hilo_we` is issued, or the pending one is suppressed.
  - `ex_flush` in IDLE discards the request and stays IDLE.
- **Divisor zero**: without the config macro, it runs through the divider normally; the result is 0/0 and is written to HI/LO.
- **Reset values**: every registered output is 0. The state is IDLE.

## Timing
- Request first seen at cycle 0; `ex_stall` = 1 from cycle 0.
- `div_start` is high from cycle 1.
- The divider finishes at cycle 35: `div_busy` falls and the result is captured.
- DONE is cycle 36: `hilo_we` = 1 and `ex_stall` = 0, so the instruction advances at the end of cycle 36.
- The earliest next request is seen at cycle 37; the divider is back in idle by then because start was low at cycle 36.
- Stall length is 36 cycles. The exact `div_busy` fall is not hard-coded; the controller follows `div_busy`.

## Configuration
- Macro `DIV_SEQ_ZERO_BYPASS_EN`.
- **Defined**: in IDLE, `ex_op_b` == 0 completes without launching the divider. `ex_stall` = 0, the next state is IDLE, `hilo_we` is not asserted, and HI/LO are left unchanged (architecturally unpredictable).
- **Not defined**: divide-by-zero is launched like any other request, as described in Operation.

## Structure
- Shared package `div_seq_pkg`:
  - state enum `div_seq_state_t`;
  - `DIV_FLUSH_CYCLES` = 2.
- No sub-module. The divider instance lives in the EXE wrapper beside this controller.

## Test plan
- **divu**: `divu` 100/7 -> `hilo_we` at cycle 36, `lo_wdata` = 14, `hi_wdata` = 2; `ex_stall` high for cycles 0–35.
- **div signed**: `div` 0xFFFFFFF9 (-7)/2 -> `lo_wdata` = 0xFFFFFFFD, `hi_wdata` = 0xFFFFFFFF.
- **Flush mid-run**: flush at cycle 10 of a run -> `div_clr` high for 2 cycles, no `hilo_we`, IDLE by cycle 13. A new `divu` 9/3 then gives lo = 3, hi = 0.
- **Hold in DONE**: `ex_hold` = 1 for 3 cycles in DONE -> exactly one `hilo_we` pulse, no relaunch, and `div_start` stays 0.
- **Back-to-back**: `divu` 10/3 then `divu` 20/6 -> writes (1,3) then (2,3), the second request launching at cycle 38.
- **Divide by zero**: `divu` 5/0 -> macro off: write lo = 0, hi = 0. Macro on: no stall, no `hilo_we`.
